// File: rtl/lsu_pkg.sv
// Shared LSU definitions: FSM state encoding, decoder mem_size/wbmask encodings
// and the alignment rule used by the load/store datapath.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

    localparam logic [3:0] WBMASK_BYTE = 4'b0001;
    localparam logic [3:0] WBMASK_HALF = 4'b0011;
    localparam logic [3:0] WBMASK_WORD = 4'b1111;

    // Size 2'b11 is not a legal access width, so it always faults.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            MEM_SIZE_BYTE: return 1'b0;
            MEM_SIZE_HALF: return off[0];
            MEM_SIZE_WORD: return |off;
            default:       return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store strobe/data shifting, load extraction with
// sign/zero extension, and the request-side misalignment check.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int REG_END_WORD = 31
) (
    input  logic [1:0]            chk_off_i,
    input  logic [1:0]            chk_size_i,
    input  logic [1:0]            off_i,
    input  logic [1:0]            size_i,
    input  logic                  sign_i,
    input  logic [3:0]            wbmask_i,
    input  logic [REG_END_WORD:0] wdata_i,
    input  logic [REG_END_WORD:0] rdata_i,
    output logic [3:0]            wstrb_o,
    output logic [REG_END_WORD:0] wdata_o,
    output logic [REG_END_WORD:0] load_o,
    output logic                  misaligned_o
);

    logic [4:0]            bit_off;
    logic [REG_END_WORD:0] sh;

    assign bit_off      = {off_i, 3'b000};
    assign wstrb_o      = wbmask_i << off_i;
    assign wdata_o      = wdata_i << bit_off;
    assign sh           = rdata_i >> bit_off;
    assign misaligned_o = is_misaligned(chk_size_i, chk_off_i);

    // NOTE: a default arm covers every size value, so load_o is always assigned and no latch is inferred.
    always_comb begin
        case (size_i)
            MEM_SIZE_BYTE: load_o = {{(REG_END_WORD - 7){sign_i & sh[7]}}, sh[7:0]};
            MEM_SIZE_HALF: load_o = {{(REG_END_WORD - 15){sign_i & sh[15]}}, sh[15:0]};
            default:       load_o = sh;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one memory op at a time, issues it on a word-addressed
// valid/ready port and returns an extended load result or a fault.
module lsu
    import lsu_pkg::*;
#(
    parameter int REG_END_WORD = 31,
    parameter int REG_END_ID   = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [REG_END_WORD:0] req_addr,
    input  logic [REG_END_WORD:0] req_wdata,
    input  logic                  req_wen,
    input  logic [3:0]            req_wbmask,
    input  logic [1:0]            req_size,
    input  logic                  req_sign,
    input  logic [REG_END_ID:0]   req_rd,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [REG_END_WORD:0] mem_addr,
    output logic                  mem_wen,
    output logic [3:0]            mem_wstrb,
    output logic [REG_END_WORD:0] mem_wdata,
    input  logic                  mem_rvalid,
    input  logic [REG_END_WORD:0] mem_rdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [REG_END_WORD:0] rsp_data,
    output logic [REG_END_ID:0]   rsp_rd,
    output logic                  rsp_wen,
    output logic                  rsp_fault
);

    lsu_state_e            state_q, state_d;
    logic [REG_END_WORD:0] addr_q, wdata_q, rsp_data_q;
    logic                  wen_q, sign_q, fault_q;
    logic [3:0]            wbmask_q;
    logic [1:0]            size_q;
    logic [REG_END_ID:0]   rd_q;
    logic                  accept, capture, req_misaligned;
    logic [REG_END_WORD:0] load_ext;

    lsu_align #(.REG_END_WORD(REG_END_WORD)) u_align (
        .chk_off_i   (req_addr[1:0]),
        .chk_size_i  (req_size),
        .off_i       (addr_q[1:0]),
        .size_i      (size_q),
        .sign_i      (sign_q),
        .wbmask_i    (wbmask_q),
        .wdata_i     (wdata_q),
        .rdata_i     (mem_rdata),
        .wstrb_o     (mem_wstrb),
        .wdata_o     (mem_wdata),
        .load_o      (load_ext),
        .misaligned_o(req_misaligned)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: if (req_valid) begin
                accept  = 1'b1;
                state_d = req_misaligned ? ST_RESP : ST_ISSUE;
            end
            ST_ISSUE: if (mem_ready) begin
                if (wen_q) begin
                    state_d = ST_RESP;
                end else if (mem_rvalid) begin
                    capture = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: if (mem_rvalid) begin
                capture = 1'b1;
                state_d = ST_RESP;
            end
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            wen_q      <= 1'b0;
            wbmask_q   <= '0;
            size_q     <= '0;
            sign_q     <= 1'b0;
            rd_q       <= '0;
            fault_q    <= 1'b0;
            rsp_data_q <= '0;
        end else if (accept) begin
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            wen_q      <= req_wen;
            wbmask_q   <= req_wbmask;
            size_q     <= req_size;
            sign_q     <= req_sign;
            rd_q       <= req_rd;
            fault_q    <= req_misaligned;
            rsp_data_q <= '0;
        end else if (capture) begin
            rsp_data_q <= load_ext;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign mem_valid = (state_q == ST_ISSUE);
    assign mem_addr  = {addr_q[REG_END_WORD:2], 2'b00};
    assign mem_wen   = wen_q;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_rd    = rd_q;
    assign rsp_fault = fault_q;
    // Writeback is gated by RESP so an idle or reset unit never claims a write.
    assign rsp_wen   = (state_q == ST_RESP) && !wen_q && !fault_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: directed ops push expected memory requests and
// responses; a negedge monitor pops and compares them on each handshake.
module tb_lsu;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } mem_exp_t;

    typedef struct {
        logic [31:0] data;
        logic        wen;
        logic        fault;
        logic [4:0]  rd;
        int          lat;
    } rsp_exp_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_wen, req_sign;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wbmask;
    logic [1:0]  req_size;
    logic [4:0]  req_rd;
    logic        mem_valid, mem_ready, mem_wen, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        rsp_valid, rsp_ready, rsp_wen, rsp_fault;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    mem_exp_t mem_q[$];
    rsp_exp_t rsp_q[$];

    lsu dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wen(req_wen), .req_wbmask(req_wbmask),
        .req_size(req_size), .req_sign(req_sign), .req_rd(req_rd),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_rd(rsp_rd), .rsp_wen(rsp_wen), .rsp_fault(rsp_fault)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor state
    logic        mem_stall_prev = 1'b0, rsp_stall_prev = 1'b0, rsp_seen = 1'b0;
    logic [31:0] p_maddr, p_mwdata, p_rdata;
    logic [3:0]  p_mstrb;
    logic        p_mwen, p_rwen, p_rfault;
    logic [4:0]  p_rrd;
    int          acc_cyc = 0, lat_meas = 0;

    always @(negedge clock) begin
        if (!reset_n) begin
            mem_stall_prev = 1'b0;
            rsp_stall_prev = 1'b0;
            rsp_seen       = 1'b0;
        end else begin
            if (req_valid && req_ready) acc_cyc = cyc;

            if (mem_stall_prev) begin
                check("mem_hold_valid", 32'(mem_valid), 32'd1);
                check("mem_hold_addr",  mem_addr, p_maddr);
                check("mem_hold_wen",   32'(mem_wen), 32'(p_mwen));
                check("mem_hold_wstrb", 32'(mem_wstrb), 32'(p_mstrb));
                check("mem_hold_wdata", mem_wdata, p_mwdata);
            end
            if (mem_valid) begin
                check("mem_expected", 32'(mem_q.size() > 0), 32'd1);
                if (mem_ready && mem_q.size() > 0) begin
                    mem_exp_t m;
                    m = mem_q.pop_front();
                    check("mem_addr",  mem_addr, m.addr);
                    check("mem_wen",   32'(mem_wen), 32'(m.wen));
                    check("mem_wstrb", 32'(mem_wstrb), 32'(m.strb));
                    check("mem_wdata", mem_wdata, m.wdata);
                end
            end
            mem_stall_prev = mem_valid && !mem_ready;
            p_maddr = mem_addr; p_mwen = mem_wen; p_mstrb = mem_wstrb; p_mwdata = mem_wdata;

            if (rsp_stall_prev) begin
                check("rsp_hold_valid", 32'(rsp_valid), 32'd1);
                check("rsp_hold_data",  rsp_data, p_rdata);
                check("rsp_hold_rd",    32'(rsp_rd), 32'(p_rrd));
                check("rsp_hold_wen",   32'(rsp_wen), 32'(p_rwen));
                check("rsp_hold_fault", 32'(rsp_fault), 32'(p_rfault));
                check("req_ready_low",  32'(req_ready), 32'd0);
            end
            if (rsp_valid) begin
                if (!rsp_seen) begin
                    rsp_seen = 1'b1;
                    lat_meas = cyc - acc_cyc;
                end
                check("rsp_expected", 32'(rsp_q.size() > 0), 32'd1);
                if (rsp_ready && rsp_q.size() > 0) begin
                    rsp_exp_t r;
                    r = rsp_q.pop_front();
                    check("rsp_data",  rsp_data, r.data);
                    check("rsp_wen",   32'(rsp_wen), 32'(r.wen));
                    check("rsp_fault", 32'(rsp_fault), 32'(r.fault));
                    check("rsp_rd",    32'(rsp_rd), 32'(r.rd));
                    if (r.lat >= 0) check("rsp_latency", 32'(lat_meas), 32'(r.lat));
                    rsp_seen = 1'b0;
                end
            end
            rsp_stall_prev = rsp_valid && !rsp_ready;
            p_rdata = rsp_data; p_rrd = rsp_rd; p_rwen = rsp_wen; p_rfault = rsp_fault;
        end
    end

    // mstall: cycles of mem_ready low; rgap: 0 = rvalid with the handshake,
    // otherwise cycles spent in WAIT before rvalid; rstall: cycles of rsp_ready low.
    task automatic do_op(
        input logic [31:0] addr, input logic [31:0] wdata, input logic wen,
        input logic [3:0] mask, input logic [1:0] size, input logic sign,
        input logic [4:0] rd, input logic [31:0] rdata,
        input int mstall, input int rgap, input int rstall,
        input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
        input logic [31:0] exp_data, input logic exp_fault, input int exp_lat);
        int n;
        if (!exp_fault) mem_q.push_back('{addr & 32'hFFFF_FFFC, wen, exp_strb, exp_wdata});
        rsp_q.push_back('{exp_data, !wen && !exp_fault, exp_fault, rd, exp_lat});
        rsp_ready  = (rstall == 0);
        req_valid  = 1'b1;
        req_addr   = addr;
        req_wdata  = wdata;
        req_wen    = wen;
        req_wbmask = mask;
        req_size   = size;
        req_sign   = sign;
        req_rd     = rd;
        @(posedge clock); #1;
        req_valid = 1'b0;
        if (!exp_fault) begin
            for (int i = 0; i < mstall; i++) begin @(posedge clock); #1; end
            mem_ready = 1'b1;
            if (!wen && rgap == 0) begin mem_rvalid = 1'b1; mem_rdata = rdata; end
            @(posedge clock); #1;
            mem_ready  = 1'b0;
            mem_rvalid = 1'b0;
            if (!wen && rgap > 0) begin
                for (int i = 0; i < rgap - 1; i++) begin @(posedge clock); #1; end
                mem_rvalid = 1'b1;
                mem_rdata  = rdata;
                @(posedge clock); #1;
                mem_rvalid = 1'b0;
            end
        end
        n = 0;
        while (!rsp_valid && n < 50) begin @(posedge clock); #1; n++; end
        if (!rsp_valid) check("rsp_timeout", 32'(rsp_valid), 32'd1);
        for (int i = 0; i < rstall; i++) begin @(posedge clock); #1; end
        rsp_ready = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_mem_valid"}, 32'(mem_valid), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_mem_addr"},  mem_addr, 32'd0);
        check({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_rsp_data"},  rsp_data, 32'd0);
        check({tag, "_rsp_flags"}, 32'({rsp_wen, rsp_fault, mem_wen}), 32'd0);
        check({tag, "_rsp_rd"},    32'(rsp_rd), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_wen = 1'b0;
        req_wbmask = '0; req_size = '0; req_sign = 1'b0; req_rd = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        check_reset_values("reset");

        //     addr          wdata         wen   mask     sz     sgn  rd  rdata         ms rg rs  strb     wdata         data          flt lat
        do_op(32'h0000_1003, 32'h0,        1'b0, 4'b0000, 2'b00, 1'b1, 5, 32'h80AA_BBCC, 0, 0, 0, 4'b0000, 32'h0,        32'hFFFF_FF80, 1'b0, 2);
        do_op(32'h0000_2002, 32'h0,        1'b0, 4'b0000, 2'b01, 1'b0, 6, 32'hF00D_1234, 0, 2, 0, 4'b0000, 32'h0,        32'h0000_F00D, 1'b0, -1);
        do_op(32'h0000_3001, 32'h0000_00AB, 1'b1, 4'b0001, 2'b00, 1'b0, 7, 32'h0,        0, 0, 0, 4'b0010, 32'h0000_AB00, 32'h0,        1'b0, 2);
        do_op(32'h0000_4002, 32'h0,        1'b0, 4'b1111, 2'b10, 1'b0, 8, 32'h0,        0, 0, 0, 4'b0000, 32'h0,        32'h0,         1'b1, 1);
        do_op(32'h0000_5000, 32'hDEAD_BEEF, 1'b1, 4'b1111, 2'b10, 1'b0, 9, 32'h0,        3, 0, 2, 4'b1111, 32'hDEAD_BEEF, 32'h0,        1'b0, -1);
        do_op(32'h0000_6004, 32'h0,        1'b0, 4'b0000, 2'b10, 1'b0, 10, 32'h1234_5678, 1, 1, 0, 4'b0000, 32'h0,       32'h1234_5678, 1'b0, -1);
        do_op(32'h0000_7002, 32'h0,        1'b0, 4'b0000, 2'b01, 1'b1, 11, 32'h8001_7FFF, 0, 0, 0, 4'b0000, 32'h0,       32'hFFFF_8001, 1'b0, 2);
        do_op(32'h0000_8001, 32'h0,        1'b0, 4'b0000, 2'b00, 1'b0, 12, 32'h0000_F000, 0, 0, 1, 4'b0000, 32'h0,       32'h0000_00F0, 1'b0, 2);
        do_op(32'h0000_9000, 32'h0,        1'b0, 4'b0000, 2'b11, 1'b1, 13, 32'h0,        0, 0, 2, 4'b0000, 32'h0,        32'h0,         1'b1, 1);
        do_op(32'h0000_A001, 32'h0000_1234, 1'b1, 4'b0011, 2'b01, 1'b0, 14, 32'h0,       0, 0, 0, 4'b0000, 32'h0,        32'h0,         1'b1, 1);
        do_op(32'h0000_B002, 32'h0000_CAFE, 1'b1, 4'b0011, 2'b01, 1'b0, 15, 32'h0,       0, 0, 0, 4'b1100, 32'hCAFE_0000, 32'h0,        1'b0, 2);

        // Reset while waiting for read data; the late rvalid must be ignored.
        mem_q.push_back('{32'h0000_C000, 1'b0, 4'b0000, 32'h0});
        req_valid = 1'b1; req_addr = 32'h0000_C000; req_wen = 1'b0; req_wdata = '0;
        req_wbmask = 4'b0000; req_size = 2'b10; req_sign = 1'b0; req_rd = 5'd16;
        @(posedge clock); #1;
        req_valid = 1'b0;
        mem_ready = 1'b1;
        @(posedge clock); #1;
        mem_ready = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        @(posedge clock); #1;
        mem_rvalid = 1'b0;
        check_reset_values("post_reset");
        repeat (3) @(posedge clock);
        #1 check("post_reset_idle", 32'({rsp_valid, req_ready}), 32'b01);

        check("mem_queue_drained", 32'(mem_q.size()), 32'd0);
        check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
